mv_spislave: RTL and testbench

- SPI target (slave) that answers the team's SPI master; it is the far end of the same link.
- Mode 3 (CPOL=1, CPHA=1), MSB first: the master drives MOSI on falling SCLK and samples MISO on rising SCLK.
- SCLK, MOSI and CS_N are asynchronous pins; the block oversamples them on the local clk.
- Exchanges bytes with local logic through a TX holding register (valid/ready) and an RX strobe.

---
 rtl/mv_spislave_pkg.sv | 26 ++
 rtl/mv_spislave_if.sv | 36 +++
 rtl/mv_spislave_sync_edge.sv | 43 ++++
 rtl/mv_spislave.sv | 176 +++++++++++++++++
 tb/tb_mv_spislave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mv_spislave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mv_spi_pkg
//  Description : Shared SPI definitions: word width, idle transmit word,
//                FSM state encoding and the SPI mode constants used by both
//                ends of the link.
//  Revision    : 1.0  initial release
// ============================================================================
package mv_spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_IDLE_TX = 8'hFF;

  // Mode 3: SCLK idles high, data launched on the leading (falling) edge
  // and sampled on the trailing (rising) edge.
  localparam bit CPOL = 1'b1;
  localparam bit CPHA = 1'b1;

  // One-hot state encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mv_spislave_if.sv
`default_nettype none
// ============================================================================
//  Module      : mv_spislave_if
//  Description : Local-side byte interface of the SPI target.
//                master modport : local logic (offers TX words, sees RX)
//                slave  modport : the SPI target itself
//                tx_data/tx_valid/tx_ready : TX holding register handshake
//                rx_data/rx_strobe         : received word + one-cycle pulse
//                tx_underrun               : idle word sent at byte start
//                busy                      : synchronized chip select active
//  Revision    : 1.0  initial release
// ============================================================================
interface mv_spislave_if #(
  parameter int DATA_W = mv_spi_pkg::SPI_DATA_W
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_strobe;
  logic              tx_underrun;
  logic              busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_strobe, tx_underrun, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_strobe, tx_underrun, busy
  );

endinterface
`default_nettype wire

// File: rtl/mv_spislave_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : mv_sync_edge
//  Description : SYNC_STAGES-deep pin synchronizer (SYNC_STAGES >= 2) with
//                one extra register for edge detection.
//                clk, reset : system clock, async active-high reset
//                din        : asynchronous pin
//                dout       : synchronized level
//                rise, fall : one-cycle pulses on synchronized edges
//  Revision    : 1.0  initial release
// ============================================================================
module mv_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   last;

  // Resetting to the pin's idle level keeps a reset from looking like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      last  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      last  <= chain[SYNC_STAGES-1];
    end
  end

  assign dout = chain[SYNC_STAGES-1];
  assign rise = dout & ~last;
  assign fall = ~dout & last;

endmodule
`default_nettype wire

// File: rtl/mv_spislave.sv
`default_nettype none
// ============================================================================
//  Module      : mv_spislave
//  Description : SPI target, MSB first, oversampling SCLK/CS_N/MOSI on clk.
//                clk, reset     : system clock, async active-high reset
//                bus (slave)    : TX holding register handshake, RX word and
//                                 strobe, underrun pulse, busy
//                sclk,cs_n,mosi : asynchronous SPI pins
//                miso, miso_oe  : serial data out and its pad enable
//  Revision    : 1.0  initial release
// ============================================================================
module mv_spislave
  import mv_spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = DATA_W'(SPI_IDLE_TX)
) (
  input  logic              clk,
  input  logic              reset,
  mv_spislave_if.slave      bus,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  // Launch edge is the leading edge when CPHA=1, the trailing one otherwise.
  // A CPHA=0 target would also need to present bit 0 on CS_N falling, which
  // this block does not do; only the edge roles follow the constants.
  localparam bit LAUNCH_ON_FALL = (CPOL == CPHA);

  // Pin capture: all three pins see the same depth so they stay aligned.
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  mv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  mv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  mv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = cs_rise | cs_fall | mosi_rise | mosi_fall | sclk_s;

  logic launch, capture;
  assign launch  = LAUNCH_ON_FALL ? sclk_fall : sclk_rise;
  assign capture = LAUNCH_ON_FALL ? sclk_rise : sclk_fall;

  // State and datapath registers.
  state_t            state,      state_nxt;
  logic [CNT_W-1:0]  bit_cnt,    bit_cnt_nxt;
  logic [DATA_W-1:0] tx_shift,   tx_shift_nxt;
  logic [DATA_W-1:0] rx_shift,   rx_shift_nxt;
  logic [DATA_W-1:0] rx_word,    rx_word_nxt;
  logic [DATA_W-1:0] hold_data,  hold_data_nxt;
  logic              hold_full,  hold_full_nxt;
  logic              rx_pulse,   rx_pulse_nxt;
  logic              underrun,   underrun_nxt;
  logic              miso_nxt;
  logic              write, load_hold;
  logic [DATA_W-1:0] word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_word   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      rx_pulse  <= 1'b0;
      underrun  <= 1'b0;
      miso      <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      tx_shift  <= tx_shift_nxt;
      rx_shift  <= rx_shift_nxt;
      rx_word   <= rx_word_nxt;
      hold_data <= hold_data_nxt;
      hold_full <= hold_full_nxt;
      rx_pulse  <= rx_pulse_nxt;
      underrun  <= underrun_nxt;
      miso      <= miso_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    tx_shift_nxt  = tx_shift;
    rx_shift_nxt  = rx_shift;
    rx_word_nxt   = rx_word;
    hold_data_nxt = hold_data;
    rx_pulse_nxt  = 1'b0;
    underrun_nxt  = 1'b0;
    miso_nxt      = miso;
    load_hold     = 1'b0;
    word          = tx_shift;

    // Writes only happen into an empty register, and byte-start loads only
    // take from a full one, so the two never collide. A write landing on
    // the byte-start cycle is therefore held for the next byte.
    write = bus.tx_valid & ~hold_full;
    if (write) begin
      hold_data_nxt = bus.tx_data;
    end

    if (cs_s) begin
      // Deselect: drop any partial word; the holding register is untouched.
      state_nxt    = ST_IDLE;
      bit_cnt_nxt  = '0;
      rx_shift_nxt = '0;
      miso_nxt     = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (launch) begin
            if (bit_cnt == '0) begin
              if (hold_full) begin
                word      = hold_data;
                load_hold = 1'b1;
              end else begin
                word         = IDLE_TX;
                underrun_nxt = 1'b1;
              end
            end
            miso_nxt     = word[DATA_W-1];
            tx_shift_nxt = {word[DATA_W-2:0], 1'b0};
          end else if (capture) begin
            rx_shift_nxt = {rx_shift[DATA_W-2:0], mosi_s};
            if (bit_cnt == LAST_BIT) begin
              rx_word_nxt  = rx_shift_nxt;
              rx_pulse_nxt = 1'b1;
              bit_cnt_nxt  = '0;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    hold_full_nxt = write ? 1'b1 : (load_hold ? 1'b0 : hold_full);
  end

  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_word;
  assign bus.rx_strobe   = rx_pulse;
  assign bus.tx_underrun = underrun;
  assign bus.busy        = ~cs_s;
  assign miso_oe         = ~cs_s;

endmodule
`default_nettype wire

// File: tb/tb_mv_spislave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mv_spislave
//  Description : Self-checking bench for mv_spislave acting as a mode-3 SPI
//                master. Expected MISO and RX words are queued when stimulus
//                is issued; monitors pop and compare as the DUT presents them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mv_spislave;

  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi;
  logic miso, miso_oe;

  mv_spislave_if #(.DATA_W(8)) bus ();

  mv_spislave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int underruns = 0;
  int cyc = 0;
  int inj_at = -1;
  logic [7:0] inj_word = 8'h00;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  int mbits = 0;
  logic [7:0] mshift = 8'h00;
  int s0, u0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX scoreboard and pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_underrun === 1'b1) underruns++;
      if (bus.rx_strobe === 1'b1) begin
        strobes++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected no strobe", bus.rx_data);
        end else begin
          check("rx_data", bus.rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  // Master-side MISO capture on rising SCLK; CS_N high discards partial bytes.
  initial begin
    forever begin
      @(posedge sclk or posedge cs_n);
      if (cs_n === 1'b1) begin
        mbits = 0;
      end else begin
        mshift = {mshift[6:0], miso};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (exp_miso.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got %0h expected no byte", mshift);
          end else begin
            check("miso_byte", mshift, exp_miso.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.tx_valid) bus.tx_valid = 1'b0;
    cyc++;
    if (cyc == inj_at) begin
      bus.tx_data  = inj_word;
      bus.tx_valid = 1'b1;
    end
  endtask

  task automatic write_tx(input logic [7:0] w);
    int k = 0;
    while (!bus.tx_ready && k < 200) begin
      tick();
      k++;
    end
    check("tx_ready_wait", bus.tx_ready, 1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    tick();
  endtask

  // One mode-3 byte, half-period 6 clk; optional one-cycle tx write at cycle ia.
  task automatic spi_byte(input logic [7:0] b, input int ia, input logic [7:0] iw);
    cyc      = 0;
    inj_at   = ia;
    inj_word = iw;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = b[i];
      repeat (6) tick();
      sclk = 1'b1;
      repeat (6) tick();
    end
    inj_at = -1;
  endtask

  task automatic spi_edges(input logic [7:0] b, input int n);
    cyc = 0;
    for (int e = 0; e < n; e++) begin
      if (e % 2 == 0) begin
        sclk = 1'b0;
        mosi = b[7 - e / 2];
      end else begin
        sclk = 1'b1;
      end
      repeat (6) tick();
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (6) tick();
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_ready"},    bus.tx_ready,    1);
    check({tag, "_rx_data"},     bus.rx_data,     0);
    check({tag, "_rx_strobe"},   bus.rx_strobe,   0);
    check({tag, "_tx_underrun"}, bus.tx_underrun, 0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_miso"},        miso,            1);
    check({tag, "_miso_oe"},     miso_oe,         0);
  endtask

  initial begin
    reset = 1'b1;
    sclk = 1'b1;
    cs_n = 1'b1;
    mosi = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (4) tick();

    // 1: loaded word A5, MOSI 3C.
    s0 = strobes; u0 = underruns;
    write_tx(8'hA5);
    check("t1_ready_low", bus.tx_ready, 0);
    exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
    cs_low();
    check("t1_busy", bus.busy, 1);
    check("t1_miso_oe", miso_oe, 1);
    spi_byte(8'h3C, -1, 8'h00);
    check("t1_ready_high", bus.tx_ready, 1);
    cs_high();
    check("t1_busy_off", bus.busy, 0);
    check("t1_rx_held", bus.rx_data, 32'h3C);
    check("t1_strobes", strobes - s0, 1);
    check("t1_underruns", underruns - u0, 0);

    // 2: no word loaded -> idle word and one underrun.
    s0 = strobes; u0 = underruns;
    exp_miso.push_back(8'hFF); exp_rx.push_back(8'hE7);
    cs_low();
    spi_byte(8'hE7, -1, 8'h00);
    cs_high();
    check("t2_strobes", strobes - s0, 1);
    check("t2_underruns", underruns - u0, 1);

    // 3: back-to-back bytes, second word written during the first byte.
    s0 = strobes; u0 = underruns;
    write_tx(8'h01);
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h80);
    exp_rx.push_back(8'h81); exp_rx.push_back(8'h7E);
    cs_low();
    spi_byte(8'h81, 20, 8'h80);
    spi_byte(8'h7E, -1, 8'h00);
    cs_high();
    check("t3_strobes", strobes - s0, 2);
    check("t3_underruns", underruns - u0, 0);

    // 4: CS_N raised after 5 edges, then a full byte.
    s0 = strobes; u0 = underruns;
    write_tx(8'h00);
    cs_low();
    spi_edges(8'hA0, 5);
    check("t4_miso_partial", miso, 0);
    cs_high();
    sclk = 1'b1;
    repeat (8) tick();
    check("t4_busy", bus.busy, 0);
    check("t4_miso_idle", miso, 1);
    check("t4_miso_oe", miso_oe, 0);
    check("t4_strobes", strobes - s0, 0);
    check("t4_underruns", underruns - u0, 0);
    s0 = strobes; u0 = underruns;
    exp_miso.push_back(8'hFF); exp_rx.push_back(8'hC3);
    cs_low();
    spi_byte(8'hC3, -1, 8'h00);
    cs_high();
    check("t4_rx", bus.rx_data, 32'hC3);
    check("t4b_strobes", strobes - s0, 1);
    check("t4b_underruns", underruns - u0, 1);

    // 5: write lands on the byte-start fall cycle -> idle word, word next byte.
    s0 = strobes; u0 = underruns;
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h69);
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
    cs_low();
    spi_byte(8'h12, 2, 8'h69);
    check("t5_held", bus.tx_ready, 0);
    spi_byte(8'h34, -1, 8'h00);
    cs_high();
    check("t5_strobes", strobes - s0, 2);
    check("t5_underruns", underruns - u0, 1);

    // 6: reset after 3 bits, then a clean transfer.
    write_tx(8'h5A);
    cs_low();
    spi_edges(8'hF0, 6);
    write_tx(8'h77);
    check("t6_ready_low", bus.tx_ready, 0);
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    sclk = 1'b1;
    cs_n = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
    s0 = strobes; u0 = underruns;
    write_tx(8'hC9);
    exp_miso.push_back(8'hC9); exp_rx.push_back(8'h2D);
    cs_low();
    spi_byte(8'h2D, -1, 8'h00);
    cs_high();
    check("t6_rx", bus.rx_data, 32'h2D);
    check("t6_strobes", strobes - s0, 1);
    check("t6_underruns", underruns - u0, 0);

    repeat (20) tick();
    check("rx_queue_left", exp_rx.size(), 0);
    check("miso_queue_left", exp_miso.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
